npc_gate_monitor: RTL and testbench

- Reads back the three 4-bit NPC gate buses (phases a/b/c) produced by the DCMG gate generator.
- Decodes each phase into a level and reconstructs the 5-bit space-vector state index (0..26).
- Checks pattern legality and dead-time on every commutation, latches the first fault and drops a gate-enable.
- Sits between DCMG outputs and the pads and control logic, as an independent protection and readback path.

---
 rtl/npc_gate_monitor_if.sv | 24 ++
 rtl/npc_gate_monitor.sv | 217 +++++++++++++++++++++
 tb/tb_npc_gate_monitor.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_gate_monitor_if.sv
// Gate readback bundle between the DCMG gate buses and the NPC gate monitor.
interface npc_gate_monitor_if;
    logic [3:0] NPC_outa;
    logic [3:0] NPC_outb;
    logic [3:0] NPC_outc;
    logic       fault_clr;
    logic [4:0] state_out;
    logic       state_valid;
    logic       state_strobe;
    logic       fault;
    logic [2:0] fault_phase;
    logic [1:0] fault_code;
    logic       gate_en;

    modport master (
        output NPC_outa, NPC_outb, NPC_outc, fault_clr,
        input  state_out, state_valid, state_strobe, fault, fault_phase, fault_code, gate_en
    );

    modport slave (
        input  NPC_outa, NPC_outb, NPC_outc, fault_clr,
        output state_out, state_valid, state_strobe, fault, fault_phase, fault_code, gate_en
    );
endinterface

// File: rtl/npc_gate_monitor.sv
// Independent NPC gate readback: decodes per-phase levels into the space-vector index and
// polices pattern legality and dead-time, latching the first fault and dropping gate_en.
//
// state | meaning
// S_OFF | all gates off, waiting for a stable level
// S_P   | phase at positive level (1100)
// S_O   | phase at neutral level (0110)
// S_N   | phase at negative level (0011)
// S_DT  | transitional pattern held, dt_ton selects TON/TPO, cnt counts hold cycles
// S_FLT | frozen after a captured fault until fault_clr
module npc_gate_monitor #(
    parameter int DT_MIN = 50,
    parameter int DT_MAX = 200,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    npc_gate_monitor_if.slave bus
);
    typedef enum logic [2:0] {S_OFF, S_P, S_O, S_N, S_DT, S_FLT} ph_state_t;

    typedef struct packed {
        ph_state_t        st;
        logic             ton;
        logic [CNT_W-1:0] cnt;
        logic [1:0]       code;
    } ph_next_t;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_ILL  = 2'b01;
    localparam logic [1:0] C_DT   = 2'b10;
    localparam logic [1:0] C_LONG = 2'b11;

    localparam logic [3:0] PAT_P   = 4'b1100;
    localparam logic [3:0] PAT_O   = 4'b0110;
    localparam logic [3:0] PAT_N   = 4'b0011;
    localparam logic [3:0] PAT_TPO = 4'b0100;
    localparam logic [3:0] PAT_TON = 4'b0010;
    localparam logic [3:0] PAT_OFF = 4'b0000;

    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(DT_MIN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DT_MAX);

    logic [3:0]       pat_r    [3];
    ph_state_t        ph_st    [3];
    logic             dt_ton   [3];
    logic [CNT_W-1:0] cnt      [3];
    ph_next_t         nxt      [3];
    logic [1:0]       code_sel [3];
    logic [2:0]       fmask;
    logic [1:0]       fcode;
    logic             any_ill;
    logic             any_dt;
    logic             valid_nxt;
    logic [4:0]       idx_nxt;

    function automatic logic is_stable(input logic [3:0] pat);
        return (pat == PAT_P) || (pat == PAT_O) || (pat == PAT_N);
    endfunction

    function automatic logic is_legal(input logic [3:0] pat);
        return is_stable(pat) || (pat == PAT_TPO) || (pat == PAT_TON) || (pat == PAT_OFF);
    endfunction

    function automatic ph_state_t level_of(input logic [3:0] pat);
        case (pat)
            PAT_P:   return S_P;
            PAT_O:   return S_O;
            PAT_N:   return S_N;
            default: return S_OFF;
        endcase
    endfunction

    function automatic logic [4:0] lvl(input ph_state_t s);
        case (s)
            S_P:     return 5'd2;
            S_O:     return 5'd1;
            default: return 5'd0;
        endcase
    endfunction

    // From S_OFF only a stable level or staying off is acceptable.
    function automatic logic [1:0] entry_code(input logic [3:0] pat);
        return (!is_legal(pat) || pat == PAT_TPO || pat == PAT_TON) ? C_ILL : C_NONE;
    endfunction

    function automatic ph_next_t eval_phase(input ph_state_t s, input logic ton,
                                            input logic [CNT_W-1:0] c, input logic [3:0] pat);
        ph_next_t r;
        logic     is_tr;
        logic     same_tr;
        logic     exit_ok;
        r.st    = s;
        r.ton   = ton;
        r.cnt   = c;
        r.code  = C_NONE;
        is_tr   = (pat == PAT_TPO) || (pat == PAT_TON);
        same_tr = ton ? (pat == PAT_TON) : (pat == PAT_TPO);
        exit_ok = ton ? (pat == PAT_O || pat == PAT_N) : (pat == PAT_P || pat == PAT_O);
        if (!is_legal(pat)) begin
            r.code = C_ILL;
        end else begin
            case (s)
                S_OFF: begin
                    r.code = entry_code(pat);
                    if (is_stable(pat)) r.st = level_of(pat);
                end
                S_P, S_O, S_N: begin
                    if (pat == PAT_OFF) begin
                        r.st = S_OFF;
                    end else if (is_tr) begin
                        if ((pat == PAT_TPO && s != S_N) || (pat == PAT_TON && s != S_P)) begin
                            r.st  = S_DT;
                            r.ton = (pat == PAT_TON);
                            r.cnt = CNT_W'(1);
                        end else begin
                            r.code = C_ILL;
                        end
                    end else if (level_of(pat) != s) begin
                        r.code = C_DT;
                    end
                end
                S_DT: begin
                    if (pat == PAT_OFF) begin
                        r.st  = S_OFF;
                        r.cnt = '0;
                    end else if (same_tr) begin
                        if (c == CNT_MAX) r.code = C_LONG;
                        else              r.cnt  = c + CNT_W'(1);
                    end else if (is_tr || !exit_ok) begin
                        r.code = C_ILL;
                    end else if (c < CNT_MIN) begin
                        r.code = C_DT;
                    end else begin
                        r.st  = level_of(pat);
                        r.cnt = '0;
                    end
                end
                default: ;
            endcase
        end
        return r;
    endfunction

    // While faulted, a clear request is judged as if every phase re-entered from S_OFF.
    always_comb begin
        fmask     = '0;
        any_ill   = 1'b0;
        any_dt    = 1'b0;
        valid_nxt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt[i]      = eval_phase(ph_st[i], dt_ton[i], cnt[i], pat_r[i]);
            code_sel[i] = bus.fault ? entry_code(pat_r[i]) : nxt[i].code;
            fmask[i]    = |code_sel[i];
            if (code_sel[i] == C_ILL) any_ill = 1'b1;
            if (code_sel[i] == C_DT)  any_dt  = 1'b1;
            if (!(nxt[i].st inside {S_P, S_O, S_N})) valid_nxt = 1'b0;
        end
        fcode   = any_ill ? C_ILL : (any_dt ? C_DT : C_LONG);
        idx_nxt = lvl(nxt[2].st) * 5'd9 + lvl(nxt[1].st) * 5'd3 + lvl(nxt[0].st);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                pat_r[i]  <= '0;
                ph_st[i]  <= S_OFF;
                dt_ton[i] <= 1'b0;
                cnt[i]    <= '0;
            end
            bus.state_out    <= '0;
            bus.state_valid  <= 1'b0;
            bus.state_strobe <= 1'b0;
            bus.fault        <= 1'b0;
            bus.fault_phase  <= '0;
            bus.fault_code   <= C_NONE;
            bus.gate_en      <= 1'b1;
        end else begin
            pat_r[2]         <= bus.NPC_outa;
            pat_r[1]         <= bus.NPC_outb;
            pat_r[0]         <= bus.NPC_outc;
            bus.state_strobe <= 1'b0;
            if (!bus.fault || bus.fault_clr) begin
                if (|fmask) begin
                    bus.fault       <= 1'b1;
                    bus.gate_en     <= 1'b0;
                    bus.fault_phase <= fmask;
                    bus.fault_code  <= fcode;
                    bus.state_valid <= 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        ph_st[i] <= S_FLT;
                        cnt[i]   <= '0;
                    end
                end else if (bus.fault) begin
                    bus.fault       <= 1'b0;
                    bus.gate_en     <= 1'b1;
                    bus.fault_phase <= '0;
                    bus.fault_code  <= C_NONE;
                    bus.state_valid <= 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        ph_st[i] <= S_OFF;
                        cnt[i]   <= '0;
                    end
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        ph_st[i]  <= nxt[i].st;
                        dt_ton[i] <= nxt[i].ton;
                        cnt[i]    <= nxt[i].cnt;
                    end
                    bus.state_valid  <= valid_nxt;
                    bus.state_strobe <= valid_nxt && (!bus.state_valid || idx_nxt != bus.state_out);
                    if (valid_nxt) bus.state_out <= idx_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_npc_gate_monitor.sv
// Scoreboard bench for npc_gate_monitor: a pattern-history reference model predicts every
// output cycle; a negedge monitor pops and compares the DUT against those predictions.
module tb_npc_gate_monitor;
    localparam int DT_MIN = 50;
    localparam int DT_MAX = 200;

    localparam logic [3:0] PP  = 4'b1100;
    localparam logic [3:0] PO  = 4'b0110;
    localparam logic [3:0] PN  = 4'b0011;
    localparam logic [3:0] TPO = 4'b0100;
    localparam logic [3:0] TON = 4'b0010;

    typedef struct packed {
        logic [4:0] so;
        logic       sv;
        logic       ss;
        logic       f;
        logic [2:0] fp;
        logic [1:0] fc;
        logic       ge;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    npc_gate_monitor_if bus();

    npc_gate_monitor #(.DT_MIN(DT_MIN), .DT_MAX(DT_MAX), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t       q [$];
    exp_t       mon_e;
    exp_t       mon_a;
    int         checks = 0;
    int         errors = 0;
    int         mon_cyc = 0;
    logic [3:0] drv [3];
    int         hold_left [3];

    // Reference model state: pattern history per phase (index 2=a, 1=b, 0=c).
    logic [3:0] m_rpat [3];
    logic [3:0] m_prev [3];
    int         m_run  [3];
    logic       m_fault;
    logic [2:0] m_phase;
    logic [1:0] m_code;
    logic [4:0] m_out;
    logic       m_valid;
    logic       m_strobe;
    logic       m_gate;

    // Doubled level: stable P/O/N = 4/2/0, transitionals sit between them (3, 1).
    function automatic int dbl(input logic [3:0] p);
        case (p)
            4'b1100: return 4;
            4'b0100: return 3;
            4'b0110: return 2;
            4'b0010: return 1;
            4'b0011: return 0;
            4'b0000: return -1;
            default: return -2;
        endcase
    endfunction

    function automatic logic [3:0] pat_of(input int d);
        case (d)
            4:       return 4'b1100;
            3:       return 4'b0100;
            2:       return 4'b0110;
            1:       return 4'b0010;
            0:       return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    // prev has been present for run cycles; cur is this cycle's pattern.
    function automatic int judge(input logic [3:0] prev, input int run, input logic [3:0] cur);
        int c;
        int p;
        int diff;
        c = dbl(cur);
        p = dbl(prev);
        diff = c - p;
        if (diff < 0) diff = -diff;
        if (c == -2) return 1;
        if (cur == prev) return (c % 2 == 1 && run >= DT_MAX) ? 3 : 0;
        if (c == -1) return 0;
        if (p == -1) return (c % 2 == 1) ? 1 : 0;
        if (p % 2 == 0) begin
            if (c % 2 == 0) return 2;
            return (diff == 1) ? 0 : 1;
        end
        if (c % 2 == 1) return 1;
        if (diff != 1) return 1;
        return (run < DT_MIN) ? 2 : 0;
    endfunction

    task automatic model_step(input logic rs, input logic clr, output exp_t e);
        int         code [3];
        logic [2:0] mask;
        logic       any1;
        logic       any2;
        logic       all_st;
        int         idx;
        int         d;
        if (rs) begin
            for (int i = 0; i < 3; i++) begin
                m_prev[i] = 4'b0000;
                m_run[i]  = 0;
            end
            m_fault = 1'b0; m_phase = '0; m_code = '0; m_out = '0;
            m_valid = 1'b0; m_strobe = 1'b0; m_gate = 1'b1;
        end else if (m_fault && !clr) begin
            m_strobe = 1'b0;
        end else begin
            mask = '0; any1 = 1'b0; any2 = 1'b0;
            for (int i = 0; i < 3; i++) begin
                code[i] = m_fault ? judge(4'b0000, 0, m_rpat[i]) : judge(m_prev[i], m_run[i], m_rpat[i]);
                mask[i] = (code[i] != 0);
                if (code[i] == 1) any1 = 1'b1;
                if (code[i] == 2) any2 = 1'b1;
            end
            if (mask != 3'b000) begin
                m_fault = 1'b1; m_gate = 1'b0; m_phase = mask;
                m_code = any1 ? 2'd1 : (any2 ? 2'd2 : 2'd3);
                m_valid = 1'b0; m_strobe = 1'b0;
            end else if (m_fault) begin
                m_fault = 1'b0; m_gate = 1'b1; m_phase = '0; m_code = '0;
                m_valid = 1'b0; m_strobe = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    m_prev[i] = 4'b0000;
                    m_run[i]  = 0;
                end
            end else begin
                all_st = 1'b1;
                idx = 0;
                for (int i = 0; i < 3; i++) begin
                    m_run[i]  = (m_rpat[i] == m_prev[i]) ? m_run[i] + 1 : 1;
                    m_prev[i] = m_rpat[i];
                    d = dbl(m_rpat[i]);
                    if (d < 0 || d % 2 == 1) all_st = 1'b0;
                    else idx += (d / 2) * ((i == 2) ? 9 : ((i == 1) ? 3 : 1));
                end
                m_strobe = all_st && (!m_valid || 5'(idx) != m_out);
                if (all_st) m_out = 5'(idx);
                m_valid = all_st;
            end
        end
        e.so = m_out; e.sv = m_valid; e.ss = m_strobe; e.f = m_fault;
        e.fp = m_phase; e.fc = m_code; e.ge = m_gate;
    endtask

    task automatic step(input logic clr, input logic rs);
        exp_t e;
        bus.NPC_outa  = drv[2];
        bus.NPC_outb  = drv[1];
        bus.NPC_outc  = drv[0];
        bus.fault_clr = clr;
        rst           = rs;
        model_step(rs, clr, e);
        for (int i = 0; i < 3; i++) m_rpat[i] = rs ? 4'b0000 : drv[i];
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic check_now(input string tag, input logic [4:0] so, input logic sv, input logic ss,
                             input logic f, input logic [2:0] fp, input logic [1:0] fc, input logic ge);
        checks++;
        if (bus.state_out !== so || bus.state_valid !== sv || bus.state_strobe !== ss ||
            bus.fault !== f || bus.fault_phase !== fp || bus.fault_code !== fc || bus.gate_en !== ge) begin
            errors++;
            $display("FAIL %s: actual so=%0d v=%b s=%b f=%b ph=%b code=%b ge=%b, expected so=%0d v=%b s=%b f=%b ph=%b code=%b ge=%b",
                     tag, bus.state_out, bus.state_valid, bus.state_strobe, bus.fault, bus.fault_phase,
                     bus.fault_code, bus.gate_en, so, sv, ss, f, fp, fc, ge);
        end
    endtask

    task automatic set_pats(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        drv[2] = a;
        drv[1] = b;
        drv[0] = c;
    endtask

    task automatic clear_to(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        set_pats(a, b, c);
        hold(2);
        step(1'b1, 1'b0);
        hold(4);
    endtask

    task automatic pick_next(input int i);
        int d;
        int nd;
        int r;
        if ($urandom_range(0, 19) == 0) begin
            drv[i] = 4'($urandom);
            hold_left[i] = $urandom_range(1, 5);
        end else begin
            d = dbl(drv[i]);
            if (d < 0) nd = 2 * $urandom_range(0, 2);
            else if (d % 2 == 1) nd = ($urandom_range(0, 1) == 1) ? d + 1 : d - 1;
            else if ($urandom_range(0, 9) == 0) nd = -1;
            else begin
                nd = ($urandom_range(0, 1) == 1) ? d + 1 : d - 1;
                if (nd < 1) nd = 1;
                if (nd > 3) nd = 3;
            end
            drv[i] = pat_of(nd);
            if (nd == 1 || nd == 3) begin
                r = $urandom_range(0, 3);
                if (r < 2)       hold_left[i] = $urandom_range(45, 55);
                else if (r == 2) hold_left[i] = $urandom_range(195, 205);
                else             hold_left[i] = $urandom_range(56, 194);
            end else begin
                hold_left[i] = $urandom_range(1, 15);
            end
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            mon_a.so = bus.state_out;  mon_a.sv = bus.state_valid; mon_a.ss = bus.state_strobe;
            mon_a.f  = bus.fault;      mon_a.fp = bus.fault_phase; mon_a.fc = bus.fault_code;
            mon_a.ge = bus.gate_en;
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL outputs cyc %0d: actual so=%0d v=%b s=%b f=%b ph=%b code=%b ge=%b, expected so=%0d v=%b s=%b f=%b ph=%b code=%b ge=%b",
                         mon_cyc, mon_a.so, mon_a.sv, mon_a.ss, mon_a.f, mon_a.fp, mon_a.fc, mon_a.ge,
                         mon_e.so, mon_e.sv, mon_e.ss, mon_e.f, mon_e.fp, mon_e.fc, mon_e.ge);
            end
            mon_cyc++;
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_rpat[i]    = 4'b0000;
            hold_left[i] = 0;
        end
        set_pats(4'b0000, 4'b0000, 4'b0000);
        repeat (3) step(1'b0, 1'b1);
        check_now("reset state", 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1);

        set_pats(PP, PP, PP);             hold(5);
        set_pats(TPO, PP, PP);            hold(50);
        set_pats(PO, PP, PP);             hold(5);
        set_pats(TPO, PP, PP);            hold(49);
        set_pats(PP, PP, PP);             hold(4);

        clear_to(PP, PO, PN);
        set_pats(PP, PN, PN);             hold(3);

        clear_to(PP, PN, PN);
        set_pats(PP, PN, 4'b1110);        hold(3);

        clear_to(PO, PN, PN);
        set_pats(TON, PN, PN);            hold(200);
        set_pats(PN, PN, PN);             hold(3);
        set_pats(TON, PN, PN);            hold(201);
        set_pats(PN, PN, PN);             hold(3);
        check_now("expired dead-time", bus.state_out, 1'b0, 1'b0, 1'b1, 3'b100, 2'b11, 1'b0);

        clear_to(PP, PP, PO);
        set_pats(PP, PP, TON);            hold(10);
        set_pats(4'b1111, PP, PN);        hold(3);
        set_pats(4'b1111, PN, PN);        hold(3);

        clear_to(PN, PN, PN);
        set_pats(PN, PN, 4'b1110);        hold(3);
        set_pats(PN, PN, PN);             hold(2);
        set_pats(4'b1111, PN, PN);        hold(1);
        step(1'b1, 1'b0);                 hold(3);

        clear_to(PP, PP, PP);
        set_pats(TPO, PP, PP);            hold(20);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        set_pats(PP, PP, PP);             hold(5);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold_left[i] <= 0) pick_next(i);
                hold_left[i]--;
            end
            step(m_fault ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 49) == 0), 1'b0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
